// File: rtl/host_rd_if.sv
// host_rd_if: host byte handshake plus Wishbone B3 classic master signals for host_rd.
interface host_rd_if #(parameter int LEN_WIDTH = 16);
  logic                 start_i;
  logic [31:0]          adr_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic                 abort_i;
  logic [7:0]           data_o;
  logic                 valid_o;
  logic                 byte_ack_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [31:0]          wb_adr_o;
  logic [31:0]          wb_dat_o;
  logic [3:0]           wb_sel_o;
  logic                 wb_we_o;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic [2:0]           wb_cti_o;
  logic [1:0]           wb_bte_o;
  logic [31:0]          wb_dat_i;
  logic                 wb_ack_i;
  logic                 wb_err_i;
  modport master (
    input  start_i, adr_i, len_i, abort_i, byte_ack_i, wb_dat_i, wb_ack_i, wb_err_i,
    output data_o, valid_o, busy_o, done_o, err_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );
  modport slave (
    output start_i, adr_i, len_i, abort_i, byte_ack_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  data_o, valid_o, busy_o, done_o, err_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/host_rd.sv
// host_rd: Wishbone word reader streaming each word MSB-first as bytes to the host.
// HOST_RD_CHECKSUM_EN appends an 8-bit running-sum byte after the last data byte.
module host_rd #(
  parameter int LEN_WIDTH = 16
) (
  input logic clk_i,
  input logic rst_i,
  host_rd_if.master bus
);
`ifdef HOST_RD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, BUS, SEND, CSUM, DONE} state_t;
  logic [7:0] sum_q;
`else
  typedef enum logic [1:0] {IDLE, BUS, SEND, DONE} state_t;
`endif
  state_t               state_q;
  logic [31:0]          adr_q;
  logic [31:0]          word_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [1:0]           idx_q;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 cyc_q;
  logic                 abort_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      abort_q <= 1'b0;
`ifdef HOST_RD_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start_i) begin
          adr_q   <= bus.adr_i & 32'hFFFF_FFFC;
          cnt_q   <= bus.len_i;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          abort_q <= 1'b0;
          idx_q   <= '0;
`ifdef HOST_RD_CHECKSUM_EN
          sum_q   <= '0;
`endif
          if (bus.len_i != '0) begin
            state_q <= BUS;
            cyc_q   <= 1'b1;
          end else begin
`ifdef HOST_RD_CHECKSUM_EN
            state_q <= CSUM;
            data_q  <= '0;
            valid_q <= 1'b1;
`else
            state_q <= DONE;
`endif
          end
        end
        // An abort seen here is remembered; the open bus cycle must still finish.
        BUS: if (bus.wb_ack_i || bus.wb_err_i) begin
          cyc_q <= 1'b0;
          if (bus.wb_err_i) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (abort_q || bus.abort_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            word_q  <= {bus.wb_dat_i[23:0], 8'h00};
            data_q  <= bus.wb_dat_i[31:24];
            valid_q <= 1'b1;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end else if (bus.abort_i) begin
          abort_q <= 1'b1;
        end
        SEND: if (bus.abort_i) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else if (bus.byte_ack_i) begin
`ifdef HOST_RD_CHECKSUM_EN
          sum_q  <= sum_q + data_q;
`endif
          idx_q  <= idx_q + 2'd1;
          data_q <= word_q[31:24];
          word_q <= word_q << 8;
          if (idx_q == 2'd3) begin
            valid_q <= 1'b0;
            adr_q   <= adr_q + 32'd4;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q != LEN_WIDTH'(1)) begin
              state_q <= BUS;
              cyc_q   <= 1'b1;
            end else begin
`ifdef HOST_RD_CHECKSUM_EN
              state_q <= CSUM;
              data_q  <= sum_q + data_q;
              valid_q <= 1'b1;
`else
              state_q <= DONE;
`endif
            end
          end
        end
`ifdef HOST_RD_CHECKSUM_EN
        CSUM: if (bus.abort_i) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else if (bus.byte_ack_i) begin
          valid_q <= 1'b0;
          state_q <= DONE;
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= !bus.abort_i;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.data_o   = data_q;
  assign bus.valid_o  = valid_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.err_o    = err_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = '0;
  assign bus.wb_sel_o = 4'hF;
  assign bus.wb_we_o  = 1'b0;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_cti_o = 3'b000;
  assign bus.wb_bte_o = 2'b00;
endmodule

// File: tb/tb_host_rd.sv
// tb_host_rd: directed bench for host_rd with a Wishbone memory slave and a host byte sink.
module tb_host_rd;
`ifdef HOST_RD_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  host_rd_if #(.LEN_WIDTH(16)) bus ();
  host_rd #(.LEN_WIDTH(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [256];
  logic [31:0] bus_log [$];
  logic [7:0]  got [$];
  int          stamp [$];
  logic [31:0] exp_w [$];
  int   done_cnt = 0;
  int   cyc_n = 0;
  int   lat = 0;
  int   wcnt = 0;
  int   ack_mode = 1;
  logic man_ack = 1'b0;
  logic err_en = 1'b0;
  logic [31:0] err_adr = '0;
  logic pv = 1'b0;
  logic pa = 1'b0;
  logic [7:0] pd = '0;
  int gb, bb, db;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: responds after lat wait cycles, error on err_adr when enabled.
  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        wcnt = 0;
      end else if (bus.wb_ack_i || bus.wb_err_i) begin
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
      end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (wcnt >= lat) begin
          wcnt = 0;
          bus_log.push_back(bus.wb_adr_o);
          chk("wb_sel", {28'd0, bus.wb_sel_o}, 32'hF);
          chk("wb_we", {31'd0, bus.wb_we_o}, 32'h0);
          chk("wb_cti", {29'd0, bus.wb_cti_o}, 32'h0);
          if (err_en && bus.wb_adr_o == err_adr) bus.wb_err_i = 1'b1;
          else begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = mem[bus.wb_adr_o[9:2]];
          end
        end else wcnt++;
      end
    end
  end

  // Host sink: always ack, ack every third cycle, or follow man_ack.
  initial begin
    bus.byte_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      cyc_n++;
      #1;
      bus.byte_ack_i = (ack_mode == 1) ? 1'b1 : (ack_mode == 3) ? (cyc_n % 3 == 0) : man_ack;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pa && bus.valid_o) chk("hold", {24'd0, bus.data_o}, {24'd0, pd});
      if (bus.valid_o && bus.byte_ack_i) begin
        got.push_back(bus.data_o);
        stamp.push_back(cyc_n);
      end
      if (bus.done_o) done_cnt++;
    end
    pv = bus.valid_o && !rst;
    pa = bus.byte_ack_i;
    pd = bus.data_o;
  end

  task automatic mark();
    gb = got.size();
    bb = bus_log.size();
    db = done_cnt;
  endtask

  task automatic start(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.adr_i = a;
    bus.len_i = l;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy_o !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, bus.busy_o}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_bytes(input string tag, input bit cs);
    logic [7:0]  s;
    logic [31:0] w;
    int k;
    s = '0;
    k = gb;
    chk({tag, "_n"}, got.size() - gb, 4 * exp_w.size() + ((cs && CS) ? 1 : 0));
    foreach (exp_w[i]) begin
      w = exp_w[i];
      for (int b = 0; b < 4; b++) begin
        if (k < got.size()) chk(tag, {24'd0, got[k]}, {24'd0, w[31-8*b -: 8]});
        s += w[31-8*b -: 8];
        k++;
      end
    end
    if (cs && CS && k < got.size()) chk({tag, "_cs"}, {24'd0, got[k]}, {24'd0, s});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;
    bus.adr_i = '0;
    bus.len_i = '0;
    bus.abort_i = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | i;
    mem[8'h40] = 32'h1122_3344;
    mem[8'h80] = 32'hA1A2_A3A4;
    mem[8'h81] = 32'hB1B2_B3B4;
    mem[8'h82] = 32'hC1C2_C3C4;
    mem[8'hC0] = 32'hD1D2_D3D4;
    mem[8'h10] = 32'h0102_0304;
    mem[8'h11] = 32'hFFFF_FFFF;
    mem[8'hFF] = 32'hDEAD_BEEF;
    mem[8'h00] = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, bus.data_o}, 32'h0);
    chk("rst_valid", {31'd0, bus.valid_o}, 32'h0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'h0);
    chk("rst_done", {31'd0, bus.done_o}, 32'h0);
    chk("rst_err", {31'd0, bus.err_o}, 32'h0);
    chk("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'd0, bus.wb_stb_o}, 32'h0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    chk("rst_wbdat", bus.wb_dat_o, 32'h0);
    chk("rst_bte", {30'd0, bus.wb_bte_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    mark(); exp_w = {32'h1122_3344};
    start(32'h100, 16'd1);
    wait_idle();
    chk("basic_nbus", bus_log.size() - bb, 1);
    chk("basic_adr", bus_log[bb], 32'h100);
    chk_bytes("basic", 1'b1);
    chk("basic_done", done_cnt - db, 1);
    chk("basic_b2b", stamp[gb+3] - stamp[gb], 3);

    ack_mode = 3;
    mark(); exp_w = {32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4};
    start(32'h200, 16'd3);
    wait_idle();
    chk("multi_nbus", bus_log.size() - bb, 3);
    chk("multi_adr0", bus_log[bb], 32'h200);
    chk("multi_adr1", bus_log[bb+1], 32'h204);
    chk("multi_adr2", bus_log[bb+2], 32'h208);
    chk_bytes("multi", 1'b1);
    chk("multi_done", done_cnt - db, 1);

    ack_mode = 1; err_en = 1'b1; err_adr = 32'h304;
    mark(); exp_w = {32'hD1D2_D3D4};
    start(32'h300, 16'd4);
    wait_idle();
    chk("berr_nbus", bus_log.size() - bb, 2);
    chk("berr_adr", bus_log[bb+1], 32'h304);
    chk("berr_err", {31'd0, bus.err_o}, 32'h1);
    chk("berr_cyc", {31'd0, bus.wb_cyc_o}, 32'h0);
    chk("berr_done", done_cnt - db, 0);
    chk_bytes("berr", 1'b0);
    err_en = 1'b0;
    mark(); exp_w = {32'h1122_3344};
    start(32'h100, 16'd1);
    chk("berr_clr", {31'd0, bus.err_o}, 32'h0);
    wait_idle();
    chk_bytes("after_err", 1'b1);
    chk("after_err_done", done_cnt - db, 1);

    mark(); exp_w = {};
    start(32'h0, 16'd0);
    wait_idle();
    chk("len0_nbus", bus_log.size() - bb, 0);
    chk("len0_done", done_cnt - db, 1);
    chk_bytes("len0", 1'b1);

    mark(); exp_w = {32'h1122_3344};
    start(32'h103, 16'd1);
    wait_idle();
    chk("misal_adr", bus_log[bb], 32'h100);
    chk_bytes("misal", 1'b1);

    mark(); exp_w = {32'hDEAD_BEEF, 32'hCAFE_F00D};
    start(32'hFFFF_FFFC, 16'd2);
    wait_idle();
    chk("wrap_adr0", bus_log[bb], 32'hFFFF_FFFC);
    chk("wrap_adr1", bus_log[bb+1], 32'h0);
    chk_bytes("wrap", 1'b1);

    mark(); exp_w = {32'h0102_0304, 32'hFFFF_FFFF};
    start(32'h40, 16'd2);
    wait_idle();
    chk_bytes("csum", 1'b1);
`ifdef HOST_RD_CHECKSUM_EN
    chk("csum_06", {24'd0, got[gb+8]}, 32'h06);
`endif
    chk("csum_done", done_cnt - db, 1);

    ack_mode = 0; man_ack = 1'b0;
    mark(); exp_w = {32'h1122_3344};
    start(32'h100, 16'd1);
    repeat (4) @(posedge clk);
    start(32'h200, 16'd2);
    ack_mode = 1;
    wait_idle();
    chk("busy_nbus", bus_log.size() - bb, 1);
    chk_bytes("busy", 1'b1);
    chk("busy_done", done_cnt - db, 1);

    ack_mode = 0;
    mark();
    start(32'h100, 16'd1);
    for (int n = 0; n < 50 && bus.valid_o !== 1'b1; n++) @(negedge clk);
    chk("as_valid", {31'd0, bus.valid_o}, 32'h1);
    man_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    man_ack = 1'b0;
    @(posedge clk);
    #1;
    bus.abort_i = 1'b1;
    @(negedge clk);
    chk("as_idx2", {24'd0, bus.data_o}, 32'h33);
    @(posedge clk);
    #1;
    bus.abort_i = 1'b0;
    @(negedge clk);
    chk("as_valid0", {31'd0, bus.valid_o}, 32'h0);
    chk("as_busy0", {31'd0, bus.busy_o}, 32'h0);
    repeat (5) @(negedge clk);
    chk("as_done", done_cnt - db, 0);
    chk("as_n", got.size() - gb, 2);
    chk("as_b1", {24'd0, got[gb+1]}, 32'h22);

    ack_mode = 1; lat = 5;
    mark();
    start(32'h100, 16'd1);
    bus.abort_i = 1'b1;
    @(posedge clk);
    #1;
    bus.abort_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("ab_cyc_held", {31'd0, bus.wb_cyc_o}, 32'h1);
    wait_idle();
    chk("ab_nbus", bus_log.size() - bb, 1);
    chk("ab_nbytes", got.size() - gb, 0);
    chk("ab_done", done_cnt - db, 0);
    chk("ab_cyc", {31'd0, bus.wb_cyc_o}, 32'h0);

    lat = 20;
    start(32'h100, 16'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cyc", {31'd0, bus.wb_cyc_o}, 32'h0);
    chk("arst_stb", {31'd0, bus.wb_stb_o}, 32'h0);
    chk("arst_valid", {31'd0, bus.valid_o}, 32'h0);
    chk("arst_busy", {31'd0, bus.busy_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/host_rd.md
Name: host_rd

Overview:
- Readback path from main memory to the host; the opposite direction of host_ctrl, which loads host bytes into memory.
- A Wishbone B3 classic master fetches LEN consecutive 32-bit words starting at a host-supplied address.
- Each word is serialized into 4 bytes, MSB first (OR1K big-endian), over a valid/ack byte handshake to the host/testbench.
- Sits as an additional master on the wb_intercon, alongside dbg and hostctrl.

Parameters:
LEN_WIDTH, 16, width of word-count input; max transfer 2^LEN_WIDTH-1 words

Ports:
clk_i  in  1  clock (wb_clk)
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle request; samples adr_i/len_i
adr_i  in  32  start byte address; bits [1:0] ignored (forced 00)
len_i  in  LEN_WIDTH  number of words to read
abort_i  in  1  terminate transfer early
data_o  out  8  byte to host
valid_o  out  1  data_o valid
byte_ack_i  in  1  host consumed data_o
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse on normal completion
err_o  out  1  sticky: bus error seen; cleared by next accepted start_i
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  tied 0
wb_sel_o  out  4  4'hF
wb_we_o  out  1  tied 0
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  3'b000 (classic)
wb_bte_o  out  2  2'b00
wb_dat_i  in  32  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error

Behaviour:
- Reset (asynchronous, any state): state IDLE; data_o=0, valid_o=0, busy_o=0, done_o=0, err_o=0, wb_cyc_o=0, wb_stb_o=0, wb_adr_o=0. All outputs are registered.
- States: IDLE, BUS, SEND, (CSUM), DONE.
- IDLE:
  - start_i=1 latches adr_i[31:2],00 and len_i; clears err_o; sets busy_o.
  - len_i≠0 -> BUS; len_i=0 -> DONE.
  - start_i while busy_o=1 is ignored.
- BUS:
  - wb_cyc_o=wb_stb_o=1 from the cycle after entry (start_i at cycle N gives cyc at N+1).
  - cyc/stb and wb_adr_o are held until wb_ack_i or wb_err_i.
  - On ack: capture wb_dat_i, drop cyc/stb the same edge, byte index=0 -> SEND.
  - On err: drop cyc/stb, set err_o, clear busy_o -> IDLE; no done_o.
  - ack and err together: treated as err.
- SEND:
  - valid_o=1, data_o=word[31-8*idx -: 8].
  - data_o is held stable until byte_ack_i=1 while valid_o=1; byte_ack_i with valid_o=0 is ignored.
  - After an ack on idx<3: idx+1, valid_o stays high (back-to-back, one byte/cycle max).
  - After an ack on idx=3: valid_o=0, address +4 (wraps 32'hFFFFFFFC -> 0), count -1.
  - Then count≠0 -> BUS, count=0 -> DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0 -> IDLE.
- abort_i:
  - In SEND or DONE: -> IDLE next cycle; valid_o=0, busy_o=0, no done_o.
  - In BUS: the current bus cycle completes (ack/err honoured), then -> IDLE, no done_o.
  - abort_i in IDLE has no effect.
- Throughput: at most one word per 5 cycles plus slave latency.

Optional Feature:
- Macro: HOST_RD_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) is kept of every byte acked in SEND; it is cleared on start.
  - After the last word, state CSUM presents the sum on data_o with valid_o under the same handshake, then goes to DONE.
  - len_i=0 sends checksum 8'h00, then done_o.
  - abort_i in CSUM -> IDLE, no done_o.
- Not defined: CSUM does not exist; the last byte ack goes directly to DONE.

Test Plan:
- Basic read: mem[0x100]=32'h11223344; start adr=0x100, len=1, byte_ack_i held 1 -> one Wishbone read at 0x100 (sel=F, we=0, cti=000); bytes 11,22,33,44 on consecutive cycles; done_o one pulse; busy_o low afterwards.
- Multi-word with host backpressure: len=3 at 0x200, byte_ack_i asserted only every 3rd cycle -> addresses 0x200, 0x204, 0x208; 12 bytes in order; data_o stable while unacked; exactly one done_o.
- Bus error: slave asserts wb_err_i on second word of len=4 -> cyc drops same edge; err_o=1, no done_o; next start_i clears err_o and runs normally.
- Boundary/ignore:
  - len=0 -> done_o pulse with no Wishbone cycle (checksum build: byte 00 first).
  - adr=0x103 -> bus address 0x100.
  - start_i during busy -> ignored.
- Abort and reset:
  - abort_i during SEND idx=2 -> valid_o=0 next cycle, IDLE, no done_o.
  - abort_i during BUS with ack delayed 5 cycles -> cyc held until ack, then IDLE.
  - rst_i mid-BUS -> cyc/stb/valid_o=0 immediately (asynchronous).
- Checksum (HOST_RD_CHECKSUM_EN): words 01020304, FFFFFFFF -> 8 data bytes followed by checksum 8'h06, then done_o.
